// File: rtl/egress_demux.sv
// egress_demux: pops descriptors and bytes from the backend shared FIFOs and
// copies each frame to every MAC tx FIFO named in the descriptor's destination
// mask. Destinations that stay blocked for BLOCK_TIMEOUT cycles are dropped
// from the frame and counted in drop_cnt.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | waiting for a descriptor; pulses ptr_sfifo_rd on leaving
//  S_PTR   | descriptor read in flight
//  S_DEC   | descriptor on ptr_sfifo_dout; latch class/mask/len
//  S_WAIT  | waiting for all destinations to become ready, or timeout
//  S_DATA  | sfifo_rd high for len cycles; bytes written 2 cycles later
//  S_FLUSH | two cycles to let the last byte reach the tx data FIFOs
//  S_PWR   | tx descriptor written to the surviving destinations
module egress_demux #(
    parameter int BLOCK_TIMEOUT = 1023,
    parameter int LEN_W         = 11
) (
    input  logic             clk_sys,
    input  logic             rstn_sys,
    output logic             sfifo_rd,
    input  logic [7:0]       sfifo_dout,
    output logic             ptr_sfifo_rd,
    input  logic [LEN_W+8:0] ptr_sfifo_dout,
    input  logic             ptr_sfifo_empty,
    output logic [3:0]       tx_data_fifo_wr,
    output logic [7:0]       tx_data_fifo_din,
    input  logic [3:0]       tx_data_fifo_afull,
    output logic [3:0]       tx_ptr_fifo_wr,
    output logic [LEN_W+4:0] tx_ptr_fifo_din,
    input  logic [3:0]       tx_ptr_fifo_full,
    output logic [15:0]      drop_cnt
);

    localparam int TMR_W = (BLOCK_TIMEOUT > 1) ? $clog2(BLOCK_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(BLOCK_TIMEOUT - 1);

    typedef enum logic [6:0] {
        S_IDLE  = 7'b000_0001,
        S_PTR   = 7'b000_0010,
        S_DEC   = 7'b000_0100,
        S_WAIT  = 7'b000_1000,
        S_DATA  = 7'b001_0000,
        S_FLUSH = 7'b010_0000,
        S_PWR   = 7'b100_0000
    } state_t;

    state_t             state, state_nxt;
    logic [3:0]         mask_q, mask_nxt;
    logic [3:0]         cls_q, cls_nxt;
    logic [LEN_W-1:0]   len_q, len_nxt;
    logic [3:0]         act_mask_q, act_nxt;
    logic [TMR_W-1:0]   timer_q, timer_nxt;
    logic [LEN_W-1:0]   cnt_q, cnt_nxt;
    logic               flush_q, flush_nxt;
    logic [15:0]        drop_nxt;
    logic               ptr_rd_nxt;
    logic               sfifo_rd_nxt;
    logic [3:0]         ptr_wr_nxt;
    logic [LEN_W+4:0]   ptr_din_nxt;
    logic               rd_d1;

    logic [3:0]         d_cls;
    logic [3:0]         d_mask;
    logic [LEN_W-1:0]   d_len;
    logic               rsvd_unused;
    logic [3:0]         rdy;
    logic [3:0]         blocked;

    assign d_cls       = ptr_sfifo_dout[LEN_W+8:LEN_W+5];
    assign d_mask      = ptr_sfifo_dout[LEN_W+4:LEN_W+1];
    assign d_len       = ptr_sfifo_dout[LEN_W-1:0];
    assign rsvd_unused = ptr_sfifo_dout[LEN_W];
    assign rdy         = ~(tx_data_fifo_afull | tx_ptr_fifo_full);
    assign blocked     = mask_q & ~rdy;

    // State, frame context and registered control outputs.
    always_ff @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            state           <= S_IDLE;
            mask_q          <= 4'b0;
            cls_q           <= 4'b0;
            len_q           <= '0;
            act_mask_q      <= 4'b0;
            timer_q         <= '0;
            cnt_q           <= '0;
            flush_q         <= 1'b0;
            drop_cnt        <= 16'b0;
            ptr_sfifo_rd    <= 1'b0;
            sfifo_rd        <= 1'b0;
            tx_ptr_fifo_wr  <= 4'b0;
            tx_ptr_fifo_din <= '0;
        end else begin
            state           <= state_nxt;
            mask_q          <= mask_nxt;
            cls_q           <= cls_nxt;
            len_q           <= len_nxt;
            act_mask_q      <= act_nxt;
            timer_q         <= timer_nxt;
            cnt_q           <= cnt_nxt;
            flush_q         <= flush_nxt;
            drop_cnt        <= drop_nxt;
            ptr_sfifo_rd    <= ptr_rd_nxt;
            sfifo_rd        <= sfifo_rd_nxt;
            tx_ptr_fifo_wr  <= ptr_wr_nxt;
            tx_ptr_fifo_din <= ptr_din_nxt;
        end
    end

    // Next-state and next-output decode; the timer counts down from
    // BLOCK_TIMEOUT-1 and the drop decision is taken on its terminal count.
    always_comb begin
        state_nxt    = state;
        mask_nxt     = mask_q;
        cls_nxt      = cls_q;
        len_nxt      = len_q;
        act_nxt      = act_mask_q;
        timer_nxt    = timer_q;
        cnt_nxt      = cnt_q;
        flush_nxt    = flush_q;
        drop_nxt     = drop_cnt;
        ptr_rd_nxt   = 1'b0;
        sfifo_rd_nxt = 1'b0;
        ptr_wr_nxt   = 4'b0;
        ptr_din_nxt  = tx_ptr_fifo_din;
        case (state)
            S_IDLE: begin
                if (!ptr_sfifo_empty) begin
                    ptr_rd_nxt = 1'b1;
                    state_nxt  = S_PTR;
                end
            end
            S_PTR: begin
                state_nxt = S_DEC;
            end
            S_DEC: begin
                mask_nxt  = d_mask;
                cls_nxt   = d_cls;
                len_nxt   = d_len;
                timer_nxt = TMR_LOAD;
                if (d_len == '0) begin
                    state_nxt = S_IDLE;
                end else if (d_mask == 4'b0) begin
                    act_nxt      = 4'b0;
                    cnt_nxt      = d_len;
                    sfifo_rd_nxt = 1'b1;
                    state_nxt    = S_DATA;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (blocked == 4'b0) begin
                    act_nxt      = mask_q;
                    cnt_nxt      = len_q;
                    sfifo_rd_nxt = 1'b1;
                    state_nxt    = S_DATA;
                end else if (timer_q == '0) begin
                    act_nxt      = mask_q & rdy;
                    cnt_nxt      = len_q;
                    sfifo_rd_nxt = 1'b1;
                    state_nxt    = S_DATA;
                    if (drop_cnt != 16'hFFFF) begin
                        drop_nxt = drop_cnt + 16'd1;
                    end
                end else begin
                    timer_nxt = timer_q - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == LEN_W'(1)) begin
                    flush_nxt = 1'b1;
                    state_nxt = S_FLUSH;
                end else begin
                    cnt_nxt      = cnt_q - 1'b1;
                    sfifo_rd_nxt = 1'b1;
                end
            end
            S_FLUSH: begin
                if (flush_q) begin
                    flush_nxt = 1'b0;
                end else begin
                    ptr_wr_nxt  = act_mask_q;
                    ptr_din_nxt = {cls_q, 1'b0, len_q};
                    state_nxt   = S_PWR;
                end
            end
            S_PWR: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Byte pipeline: read strobe, then byte on sfifo_dout, then write to the
    // active destinations; act_mask is stable for the whole data phase.
    always_ff @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            rd_d1            <= 1'b0;
            tx_data_fifo_wr  <= 4'b0;
            tx_data_fifo_din <= 8'b0;
        end else begin
            rd_d1           <= sfifo_rd;
            tx_data_fifo_wr <= rd_d1 ? act_mask_q : 4'b0;
            if (rd_d1) begin
                tx_data_fifo_din <= sfifo_dout;
            end
        end
    end

endmodule

// File: tb/tb_egress_demux.sv
// Scoreboard bench for egress_demux: behavioural backend FIFOs feed the DUT,
// expected per-port byte/descriptor streams are queued at stimulus time and
// popped by a negedge monitor whenever the DUT writes.
module tb_egress_demux;

    localparam int BT = 1023;

    logic        clk_sys;
    logic        rstn_sys;
    logic        sfifo_rd;
    logic [7:0]  sfifo_dout;
    logic        ptr_sfifo_rd;
    logic [19:0] ptr_sfifo_dout;
    logic        ptr_sfifo_empty;
    logic [3:0]  tx_data_fifo_wr;
    logic [7:0]  tx_data_fifo_din;
    logic [3:0]  tx_data_fifo_afull;
    logic [3:0]  tx_ptr_fifo_wr;
    logic [15:0] tx_ptr_fifo_din;
    logic [3:0]  tx_ptr_fifo_full;
    logic [15:0] drop_cnt;

    egress_demux #(.BLOCK_TIMEOUT(BT), .LEN_W(11)) dut (
        .clk_sys            (clk_sys),
        .rstn_sys           (rstn_sys),
        .sfifo_rd           (sfifo_rd),
        .sfifo_dout         (sfifo_dout),
        .ptr_sfifo_rd       (ptr_sfifo_rd),
        .ptr_sfifo_dout     (ptr_sfifo_dout),
        .ptr_sfifo_empty    (ptr_sfifo_empty),
        .tx_data_fifo_wr    (tx_data_fifo_wr),
        .tx_data_fifo_din   (tx_data_fifo_din),
        .tx_data_fifo_afull (tx_data_fifo_afull),
        .tx_ptr_fifo_wr     (tx_ptr_fifo_wr),
        .tx_ptr_fifo_din    (tx_ptr_fifo_din),
        .tx_ptr_fifo_full   (tx_ptr_fifo_full),
        .drop_cnt           (drop_cnt)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    logic [19:0] desc_q [$];
    logic [7:0]  byte_q [$];
    logic [7:0]  exp_data [4][$];
    logic [15:0] exp_pdin [4][$];
    int          exp_mark [4][$];
    int          exp_run [$];
    int          ptr_rd_times [$];
    int          cum [4];
    int          wr_cnt [4];
    int          run_len;
    int          cyc;
    int          last_ptr_cyc;
    int          first_lat;
    bit          awaiting;
    int          rd_total;
    int          n_checks;
    int          n_fail;
    int          exp_drop;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Backend FIFO models: dout valid the cycle after the read strobe.
    always @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            ptr_sfifo_dout  <= 20'b0;
            sfifo_dout      <= 8'b0;
            ptr_sfifo_empty <= 1'b1;
        end else begin
            if (ptr_sfifo_rd && desc_q.size() > 0) ptr_sfifo_dout <= desc_q.pop_front();
            if (sfifo_rd) begin
                rd_total <= rd_total + 1;
                if (byte_q.size() > 0) sfifo_dout <= byte_q.pop_front();
            end
            ptr_sfifo_empty <= (desc_q.size() == 0);
        end
    end

    // Monitor: descriptor writes are checked before data writes so that a
    // descriptor arriving alongside its last byte is seen as too early.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (!rstn_sys) begin
                run_len  = 0;
                awaiting = 1'b0;
                for (int n = 0; n < 4; n++) wr_cnt[n] = 0;
            end else begin
                for (int n = 0; n < 4; n++) begin
                    if (tx_ptr_fifo_wr[n]) begin
                        if (exp_pdin[n].size() == 0) begin
                            chk($sformatf("port%0d_unexpected_ptr_wr", n), int'(tx_ptr_fifo_wr), 0);
                        end else begin
                            chk($sformatf("port%0d_ptr_din", n), int'(tx_ptr_fifo_din), int'(exp_pdin[n].pop_front()));
                            chk($sformatf("port%0d_bytes_before_ptr", n), wr_cnt[n], exp_mark[n].pop_front());
                        end
                    end
                end
                for (int n = 0; n < 4; n++) begin
                    if (tx_data_fifo_wr[n]) begin
                        wr_cnt[n]++;
                        if (exp_data[n].size() == 0) begin
                            chk($sformatf("port%0d_unexpected_data_wr", n), int'(tx_data_fifo_wr), 0);
                        end else begin
                            chk($sformatf("port%0d_data_byte", n), int'(tx_data_fifo_din), int'(exp_data[n].pop_front()));
                        end
                    end
                end
                if (ptr_sfifo_rd) begin
                    ptr_rd_times.push_back(cyc);
                    last_ptr_cyc = cyc;
                    awaiting     = 1'b1;
                end
                if (sfifo_rd) begin
                    if (run_len == 0 && awaiting) begin
                        first_lat = cyc - last_ptr_cyc;
                        awaiting  = 1'b0;
                    end
                    run_len++;
                end else if (run_len > 0) begin
                    if (exp_run.size() == 0) chk("unexpected_rd_run", run_len, 0);
                    else chk("rd_run_len", run_len, exp_run.pop_front());
                    run_len = 0;
                end
            end
        end
    end

    // Reference: a frame reaches every port in act; bytes in order, then one
    // descriptor {class,0,len} once all of that frame's bytes are written.
    task automatic send_frame(input logic [3:0] cls, input logic [3:0] mask,
                              input logic [10:0] len, input logic rsvd,
                              input logic [3:0] act);
        logic [7:0] b;
        desc_q.push_back({cls, mask, rsvd, len});
        for (int i = 0; i < int'(len); i++) begin
            b = 8'($urandom);
            byte_q.push_back(b);
            for (int n = 0; n < 4; n++) if (act[n]) exp_data[n].push_back(b);
        end
        if (len != 11'd0) begin
            exp_run.push_back(int'(len));
            for (int n = 0; n < 4; n++) begin
                if (act[n]) begin
                    cum[n] += int'(len);
                    exp_pdin[n].push_back({cls, 1'b0, len});
                    exp_mark[n].push_back(cum[n]);
                end
            end
        end
    endtask

    function automatic bit sb_empty();
        bit e;
        e = (desc_q.size() == 0) && (byte_q.size() == 0) && (exp_run.size() == 0);
        for (int n = 0; n < 4; n++) e = e && (exp_data[n].size() == 0) && (exp_pdin[n].size() == 0);
        return e;
    endfunction

    task automatic wait_drain(input string name, input int max_cyc);
        int i;
        i = 0;
        while (i < max_cyc && !sb_empty()) begin
            @(negedge clk_sys);
            i++;
        end
        chk({name, "_completed_in_time"}, int'(i < max_cyc), 1);
        repeat (10) @(negedge clk_sys);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_sfifo_rd"}, int'(sfifo_rd), 0);
        chk({tag, "_ptr_sfifo_rd"}, int'(ptr_sfifo_rd), 0);
        chk({tag, "_tx_data_wr"}, int'(tx_data_fifo_wr), 0);
        chk({tag, "_tx_data_din"}, int'(tx_data_fifo_din), 0);
        chk({tag, "_tx_ptr_wr"}, int'(tx_ptr_fifo_wr), 0);
        chk({tag, "_tx_ptr_din"}, int'(tx_ptr_fifo_din), 0);
        chk({tag, "_drop_cnt"}, int'(drop_cnt), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no completion, expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int i;
        rstn_sys           = 1'b0;
        tx_data_fifo_afull = 4'b0;
        tx_ptr_fifo_full   = 4'b0;
        exp_drop           = 0;
        repeat (3) @(negedge clk_sys);
        chk_outputs_zero("reset");
        rstn_sys = 1'b1;
        repeat (2) @(negedge clk_sys);

        // T1 unicast: descriptor 20'h32040
        send_frame(4'd3, 4'b0010, 11'd64, 1'b0, 4'b0010);
        wait_drain("t1", 400);
        chk("t1_ptr_to_first_rd", first_lat, 3);
        chk("t1_drop_cnt", int'(drop_cnt), exp_drop);

        // T2 broadcast, afull raised mid-frame must not cut any port
        send_frame(4'd5, 4'b1111, 11'd60, 1'b0, 4'b1111);
        i = 0;
        while (i < 50 && !sfifo_rd) begin
            @(negedge clk_sys);
            i++;
        end
        chk("t2_data_started", int'(sfifo_rd), 1);
        repeat (5) @(negedge clk_sys);
        tx_data_fifo_afull = 4'b1111;
        repeat (20) @(negedge clk_sys);
        tx_data_fifo_afull = 4'b0000;
        wait_drain("t2", 400);
        chk("t2_drop_cnt", int'(drop_cnt), exp_drop);

        // T3 blocked for 100 cycles, then released
        tx_data_fifo_afull = 4'b0100;
        base = rd_total;
        send_frame(4'd1, 4'b0100, 11'd32, 1'b0, 4'b0100);
        repeat (100) @(negedge clk_sys);
        chk("t3_no_reads_while_blocked", rd_total - base, 0);
        tx_data_fifo_afull = 4'b0000;
        wait_drain("t3", 400);
        chk("t3_drop_cnt", int'(drop_cnt), exp_drop);

        // T4 timeout: port 0 dropped, port 1 served; then a fully dropped frame
        tx_data_fifo_afull = 4'b0001;
        send_frame(4'd2, 4'b0011, 11'd40, 1'b0, 4'b0010);
        wait_drain("t4a", BT + 400);
        exp_drop = 1;
        chk("t4a_drop_cnt", int'(drop_cnt), exp_drop);
        chk("t4a_ptr_to_first_rd", first_lat, BT + 2);
        base = rd_total;
        send_frame(4'd6, 4'b0001, 11'd16, 1'b1, 4'b0000);
        wait_drain("t4b", BT + 400);
        exp_drop = 2;
        chk("t4b_drop_cnt", int'(drop_cnt), exp_drop);
        chk("t4b_bytes_drained", rd_total - base, 16);
        tx_data_fifo_afull = 4'b0000;

        // T5 edge descriptors, same check also with the ptr full flag path
        base = rd_total;
        send_frame(4'd7, 4'b0101, 11'd0, 1'b0, 4'b0101);
        wait_drain("t5_len0", 100);
        chk("t5_len0_no_reads", rd_total - base, 0);
        send_frame(4'd4, 4'b0000, 11'd8, 1'b0, 4'b0000);
        wait_drain("t5_mask0", 100);
        chk("t5_mask0_reads", rd_total - base, 8);
        chk("t5_mask0_drop_cnt", int'(drop_cnt), exp_drop);
        ptr_rd_times.delete();
        send_frame(4'd8, 4'b0001, 11'd1, 1'b0, 4'b0001);
        send_frame(4'd9, 4'b1000, 11'd1, 1'b0, 4'b1000);
        send_frame(4'd10, 4'b0110, 11'd1, 1'b0, 4'b0110);
        wait_drain("t5_b2b", 200);
        chk("t5_b2b_desc_reads", ptr_rd_times.size(), 3);
        for (int k = 1; k < ptr_rd_times.size(); k++) begin
            chk("t5_b2b_min_spacing", int'((ptr_rd_times[k] - ptr_rd_times[k-1]) >= 7), 1);
        end

        // Ptr-full blocking released before timeout
        tx_ptr_fifo_full = 4'b1000;
        send_frame(4'd11, 4'b1001, 11'd12, 1'b0, 4'b1001);
        repeat (40) @(negedge clk_sys);
        tx_ptr_fifo_full = 4'b0000;
        wait_drain("ptr_full_release", 200);
        chk("ptr_full_drop_cnt", int'(drop_cnt), exp_drop);

        // Random all-ready traffic
        for (int k = 0; k < 24; k++) begin
            logic [3:0]  c;
            logic [3:0]  m;
            logic [10:0] l;
            c = 4'($urandom_range(0, 15));
            m = 4'($urandom_range(0, 15));
            l = 11'($urandom_range(0, 40));
            send_frame(c, m, l, 1'($urandom), m);
        end
        wait_drain("random", 4000);
        chk("random_drop_cnt", int'(drop_cnt), exp_drop);

        // T6 reset in the middle of a len-100 frame
        base = rd_total;
        send_frame(4'd12, 4'b0110, 11'd100, 1'b0, 4'b0110);
        i = 0;
        while (i < 300 && (rd_total - base) < 30) begin
            @(negedge clk_sys);
            i++;
        end
        chk("t6_reached_byte30", int'((rd_total - base) >= 30), 1);
        rstn_sys = 1'b0;
        #1;
        chk_outputs_zero("t6_async_reset");
        desc_q.delete();
        byte_q.delete();
        exp_run.delete();
        for (int n = 0; n < 4; n++) begin
            exp_data[n].delete();
            exp_pdin[n].delete();
            exp_mark[n].delete();
            cum[n] = 0;
        end
        exp_drop = 0;
        repeat (3) @(negedge clk_sys);
        rstn_sys = 1'b1;
        repeat (2) @(negedge clk_sys);
        send_frame(4'd13, 4'b1001, 11'd20, 1'b1, 4'b1001);
        wait_drain("t6_after_reset", 200);
        chk("t6_ptr_to_first_rd", first_lat, 3);
        chk("t6_drop_cnt", int'(drop_cnt), exp_drop);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
